// File: rtl/audio_pkg.sv
// Shared types and defaults for the WM8731 audio transport and SRAM sequencer.
// Optional looping playback is selected with AUDIO_LOOP_PLAY_EN.
package audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_REC   = 2'd3
    } state_t;

    localparam int AUDIO_ADDR_W = 18;
    localparam int AUDIO_DATA_W = 16;
    localparam logic [17:0] AUDIO_MAX_ADDR = 18'h3FFFF;

    localparam logic [1:0] ACC_NONE = 2'd0;
    localparam logic [1:0] ACC_RD   = 2'd1;
    localparam logic [1:0] ACC_WR   = 2'd2;

endpackage

// File: rtl/audio_transport_ctrl_sram_port.sv
// Two-cycle SRAM read/write strobe sequencer with a single pending slot.
// Optional looping playback (AUDIO_LOOP_PLAY_EN) does not affect this block.
module sram_port
    import audio_pkg::*;
#(
    parameter int ADDR_W = AUDIO_ADDR_W,
    parameter int DATA_W = AUDIO_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              flush_i,
    input  logic              kill_i,
    output logic              busy_o,
    output logic              rd_done_o,
    output logic              wr_done_o,
    output logic              drop_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe_o,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic              sram_we_n_o,
    output logic              sram_oe_n_o
);

    logic [1:0]        phase_q;
    logic [1:0]        op_q;
    logic              live_q;
    logic [1:0]        pend_op_q, pend_op_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] dq_q;
    logic              dq_oe_q;
    logic              we_n_q;
    logic              oe_n_q;
    logic [1:0]        start_op;
    logic [DATA_W-1:0] start_data;
    logic              drop;
    logic              finishing;

    assign busy_o    = (phase_q != 2'd0);
    assign finishing = (phase_q == 2'd2);
    assign rd_done_o = finishing && (op_q == ACC_RD) && live_q;
    assign wr_done_o = (phase_q == 2'd1) && (op_q == ACC_WR);
    assign drop_o    = drop;
    assign rdata_o   = rdata_q;

    assign sram_addr_o  = addr_q;
    assign sram_dq_o    = dq_q;
    assign sram_dq_oe_o = dq_oe_q;
    assign sram_we_n_o  = we_n_q;
    assign sram_oe_n_o  = oe_n_q;

    // A finishing access hands the port straight to the pending request.
    always_comb begin
        start_op    = ACC_NONE;
        start_data  = wdata_i;
        drop        = 1'b0;
        pend_op_d   = pend_op_q;
        pend_data_d = pend_data_q;
        if (flush_i) begin
            pend_op_d = ACC_NONE;
        end
        if (!busy_o) begin
            start_op = req_op_i;
        end else if (finishing) begin
            if (pend_op_q != ACC_NONE && !flush_i) begin
                start_op   = pend_op_q;
                start_data = pend_data_q;
                pend_op_d  = ACC_NONE;
                drop       = (req_op_i != ACC_NONE);
            end else begin
                start_op = req_op_i;
            end
        end else if (req_op_i != ACC_NONE) begin
            if (pend_op_q != ACC_NONE && !flush_i) begin
                drop = 1'b1;
            end else begin
                pend_op_d   = req_op_i;
                pend_data_d = wdata_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q     <= 2'd0;
            op_q        <= ACC_NONE;
            live_q      <= 1'b0;
            pend_op_q   <= ACC_NONE;
            pend_data_q <= '0;
            rdata_q     <= '0;
            addr_q      <= '0;
            dq_q        <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
        end else begin
            pend_op_q   <= pend_op_d;
            pend_data_q <= pend_data_d;
            if (kill_i) begin
                live_q <= 1'b0;
            end
            if (start_op != ACC_NONE) begin
                phase_q <= 2'd1;
                op_q    <= start_op;
                live_q  <= 1'b1;
                addr_q  <= addr_i;
                dq_q    <= start_data;
                we_n_q  <= (start_op != ACC_WR);
                dq_oe_q <= (start_op == ACC_WR);
                oe_n_q  <= (start_op != ACC_RD);
            end else if (phase_q == 2'd1) begin
                phase_q <= 2'd2;
                we_n_q  <= 1'b1;
                dq_oe_q <= 1'b0;
                if (op_q == ACC_RD) begin
                    rdata_q <= sram_dq_i;
                end
            end else if (finishing) begin
                phase_q <= 2'd0;
                op_q    <= ACC_NONE;
                oe_n_q  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/audio_transport_ctrl.sv
// Transport FSM, sample pointer and record length for the board-SRAM audio path.
// Define AUDIO_LOOP_PLAY_EN to wrap playback to word 0 instead of stopping.
module audio_transport_ctrl
    import audio_pkg::*;
#(
    parameter int ADDR_W = AUDIO_ADDR_W,
    parameter int DATA_W = AUDIO_DATA_W,
    parameter logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(AUDIO_MAX_ADDR)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_play,
    input  logic              key_pause,
    input  logic              key_stop,
    input  logic              key_rec,
    input  logic              dac_req,
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_valid,
    input  logic              adc_req,
    input  logic [DATA_W-1:0] adc_data,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic [1:0]        state,
    output logic [ADDR_W:0]   rec_len,
    output logic              overrun
);

    localparam int PW = ADDR_W + 1;

    state_t            state_q, st_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     len_q, len_d;
    logic [PW-1:0]     ptr_inc;
    logic              ovr_q;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        req_op;
    logic              rd_done;
    logic              wr_done;
    logic              drop;
    logic              busy;
    logic              flush;
    logic              kill;

    assign ptr_inc   = ptr_q + PW'(1);
    assign state     = state_q;
    assign rec_len   = len_q;
    assign overrun   = ovr_q;
    assign dac_valid = valid_q;
    assign dac_data  = data_q;

    always_comb begin
        st_d    = state_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        valid_d = 1'b0;
        data_d  = data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (key_rec) begin
                    st_d  = ST_REC;
                    ptr_d = '0;
                    len_d = '0;
                end else if (key_play && len_q != '0) begin
                    st_d  = ST_PLAY;
                    ptr_d = '0;
                end
            end
            ST_PLAY: begin
                if (key_stop) begin
                    st_d = ST_IDLE;
                end else if (key_rec) begin
                    st_d  = ST_REC;
                    ptr_d = '0;
                    len_d = '0;
                end else if (key_pause) begin
                    st_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (key_stop) begin
                    st_d = ST_IDLE;
                end else if (key_play || key_pause) begin
                    st_d = ST_PLAY;
                end
            end
            ST_REC: begin
                if (key_stop) begin
                    st_d = ST_IDLE;
                end
            end
            default: st_d = ST_IDLE;
        endcase
        // A read that lands after stop or rec is silently discarded.
        if (rd_done && (st_d == ST_PLAY || st_d == ST_PAUSE)) begin
            valid_d = 1'b1;
            data_d  = rdata;
            ptr_d   = ptr_inc;
            if (ptr_inc == len_q) begin
`ifdef AUDIO_LOOP_PLAY_EN
                ptr_d = '0;
`else
                st_d = ST_IDLE;
`endif
            end
        end
        if (wr_done) begin
            ptr_d = ptr_inc;
            len_d = ptr_inc;
            if (ptr_q == {1'b0, MAX_ADDR}) begin
                st_d = ST_IDLE;
            end
        end
    end

    always_comb begin
        req_op = ACC_NONE;
        if (dac_req && state_q == ST_PLAY && st_d == ST_PLAY) begin
            req_op = ACC_RD;
        end else if (adc_req && state_q == ST_REC && st_d == ST_REC) begin
            req_op = ACC_WR;
        end
    end

    assign flush = (st_d != state_q) && busy;
    assign kill  = flush && (st_d == ST_IDLE || st_d == ST_REC);

    sram_port #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_port (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_op_i     (req_op),
        .addr_i       (ptr_d[ADDR_W-1:0]),
        .wdata_i      (adc_data),
        .flush_i      (flush),
        .kill_i       (kill),
        .busy_o       (busy),
        .rd_done_o    (rd_done),
        .wr_done_o    (wr_done),
        .drop_o       (drop),
        .rdata_o      (rdata),
        .sram_addr_o  (sram_addr),
        .sram_dq_o    (sram_dq_o),
        .sram_dq_oe_o (sram_dq_oe),
        .sram_dq_i    (sram_dq_i),
        .sram_we_n_o  (sram_we_n),
        .sram_oe_n_o  (sram_oe_n)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            len_q   <= '0;
            ovr_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= st_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            if (key_rec) begin
                ovr_q <= 1'b0;
            end
            if (drop) begin
                ovr_q <= 1'b1;
            end
        end
    end

endmodule

// File: doc/audio_transport_ctrl.md
Name: audio_transport_ctrl

Overview:
- Transport controller and SRAM sequencer for the WM8731 audio path on the board SRAM.
- Owns the single SRAM port and the sample address pointer.
- Runs an IDLE/PLAY/PAUSE/REC state machine from debounced key pulses.
- Serves next-sample requests from the DAC serializer (read) and sample-ready requests from the ADC deserializer (write). The serializers no longer drive the SRAM address.

Parameters:
- ADDR_W, 18, SRAM word address width.
- DATA_W, 16, sample width.
- MAX_ADDR, 18'h3FFFF, last usable SRAM word address.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous reset, active-low.
- key_play  in  1  one-cycle pulse.
- key_pause  in  1  one-cycle pulse.
- key_stop  in  1  one-cycle pulse.
- key_rec  in  1  one-cycle pulse.
- dac_req  in  1  one-cycle pulse: DAC wants next sample.
- dac_data  out  DATA_W  sample returned for dac_req.
- dac_valid  out  1  one-cycle pulse; dac_data is valid while it is high.
- adc_req  in  1  one-cycle pulse: adc_data holds a new sample.
- adc_data  in  DATA_W  sample to store.
- sram_addr  out  ADDR_W  SRAM address.
- sram_dq_o  out  DATA_W  write data.
- sram_dq_oe  out  1  tristate enable for sram_dq_o.
- sram_dq_i  in  DATA_W  read data.
- sram_we_n  out  1  write strobe.
- sram_oe_n  out  1  output enable.
- state  out  2  IDLE=0, PLAY=1, PAUSE=2, REC=3.
- rec_len  out  ADDR_W+1  number of words recorded.
- overrun  out  1  sticky flag: a request was dropped.

Behaviour:
- Reset (rst_n low at a clk edge) forces the following, even mid-access:
  - state=IDLE, ptr=0, rec_len=0, overrun=0, dac_valid=0, dac_data=0.
  - sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, sram_addr=0.
  - Any pending request is discarded.
- Key priority when keys coincide: stop > rec > play > pause. Keys that are invalid in the current state are ignored.
- State transitions:
  - IDLE: play with rec_len!=0 -> PLAY, ptr=0. Play with rec_len=0 is ignored. Rec -> REC, ptr=0, rec_len=0.
  - PLAY: pause -> PAUSE (ptr held). Stop -> IDLE. Rec -> REC, ptr=0, rec_len=0.
  - PAUSE: play or pause -> PLAY (resume at ptr). Stop -> IDLE.
  - REC: stop -> IDLE, rec_len holds the count written. Play and pause are ignored.
- Read access, PLAY only; dac_req is ignored in other states:
  - Cycle T (dac_req sampled): sram_addr=ptr, sram_oe_n=0.
  - T+1: capture sram_dq_i.
  - T+2: dac_valid=1 with the captured data; ptr<=ptr+1; sram_oe_n=1.
  - Latency from dac_req to dac_valid is 2 cycles.
- End of playback: when the incremented ptr equals rec_len, state -> IDLE in the same cycle as dac_valid.
- Write access, REC only; adc_req is ignored in other states:
  - Cycle T: sram_addr=ptr, sram_dq_o=adc_data (registered), sram_dq_oe=1, sram_we_n=0.
  - T+1: sram_we_n=1, sram_dq_oe=0, ptr<=ptr+1, rec_len<=ptr+1.
- Memory full: after the write to MAX_ADDR, rec_len=MAX_ADDR+1 and state -> IDLE automatically. No wrap-around on record.
- Busy handling: the access sequencer is busy for 2 (read) or 2 (write) cycles.
  - One request arriving while busy is latched as pending and served right after the current access.
  - A further request while a pending request is already held is dropped and sets overrun=1.
  - overrun is cleared only by reset or key_rec.
- Key during an access: the in-flight access completes. A stop drops the pending request and suppresses a dac_valid not yet issued. A pause lets the in-flight read complete.
- sram_we_n and sram_oe_n are never low in the same cycle. sram_dq_oe=1 only while sram_we_n=0.

Optional Feature:
- AUDIO_LOOP_PLAY_EN defined: at end of playback, ptr wraps to 0 and state stays PLAY, so playback loops until stop or pause.
- Undefined: end of playback -> IDLE, as described in Behaviour.

Decomposition:
- audio_pkg holds:
  - State encodings IDLE/PLAY/PAUSE/REC.
  - ADDR_W, DATA_W, MAX_ADDR defaults.
  - Access opcode constants ACC_NONE, ACC_RD, ACC_WR.
- One sub-module, sram_port: the 2-cycle read/write strobe sequencer with a pending slot and busy output.
- audio_transport_ctrl holds the FSM, pointer, rec_len and the end/full logic.

Test Plan:
- Reset, then rec key, then 4 adc_req spaced 8 cycles with data 16'h1111..16'h4444, then stop -> SRAM words 0..3 hold those values; rec_len=4; state=IDLE.
- Play key, then dac_req every 8 cycles -> dac_valid exactly 2 cycles after each request with 1111, 2222, 3333, 4444. After the 4th, state=IDLE. A 5th dac_req gives no dac_valid.
- Pause after the 2nd sample, then 3 dac_req, then play -> no dac_valid while paused; the next request returns 3333.
- Three dac_req on consecutive cycles -> first two are served back-to-back (valid at T+2 and T+4); third is dropped; overrun=1.
- MAX_ADDR=3 with 5 adc_req -> 4 words written; state auto to IDLE; rec_len=4; 5th request ignored with overrun=0.
- rst_n low in the cycle sram_we_n=0 -> next cycle sram_we_n=1, sram_dq_oe=0, state=IDLE, ptr=0. With AUDIO_LOOP_PLAY_EN, playback of rec_len=2 returns 1111, 2222, 1111 with state=PLAY throughout.
